// File: rtl/i2s_to_wb_pkg.sv
// Shared constants, state encoding and slot helpers for the I2S transmit serializer.
package i2s_to_wb_pkg;

  localparam int I2S_FRAME_BITS     = 32;
  localparam int I2S_WS_RIGHT_FIRST = 15;
  localparam int I2S_WS_RIGHT_LAST  = 30;
  localparam int I2S_SLOT_W         = $clog2(I2S_FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } i2s_state_e;

  // WS leads each channel's MSB by one slot, so the right window is 15..30.
  function automatic logic ws_for_slot(input logic [I2S_SLOT_W-1:0] slot);
    return (slot >= I2S_SLOT_W'(I2S_WS_RIGHT_FIRST)) &&
           (slot <= I2S_SLOT_W'(I2S_WS_RIGHT_LAST));
  endfunction

endpackage

// File: rtl/i2s_to_wb_tx_shifter_sck_gen.sv
// SCK generator: divider counter and bit-clock register with rise/fall event decodes.
module i2s_to_wb_sck_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i2s_clk_i,
  input  logic                 i2s_rst_i,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 sck,
  output logic                 rise_evt,
  output logic                 fall_evt
);

  logic [DIV_WIDTH-1:0] cnt_r;
  logic                 sck_r;
  logic                 tc_s;

  // Terminal-count decode; events only exist while running.
  always_comb begin
    tc_s     = run && (cnt_r == div);
    rise_evt = tc_s && !sck_r;
    fall_evt = tc_s && sck_r;
    sck      = sck_r;
  end

  // Divider counter and SCK toggle; held cleared with SCK low while not running.
  always_ff @(posedge i2s_clk_i) begin
    if (i2s_rst_i) begin
      cnt_r <= '0;
      sck_r <= 1'b0;
    end else if (!run) begin
      cnt_r <= '0;
      sck_r <= 1'b0;
    end else if (tc_s) begin
      cnt_r <= '0;
      sck_r <= !sck_r;
    end else begin
      cnt_r <= cnt_r + 1'b1;
      sck_r <= sck_r;
    end
  end

endmodule

// File: rtl/i2s_to_wb_tx_shifter.sv
// I2S transmit serializer: pops one stereo word per frame from a FWFT FIFO and
// shifts it out MSB-first as I2S master (SCK, WS, SD).
module i2s_to_wb_tx_shifter
  import i2s_to_wb_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i2s_clk_i,
  input  logic                 i2s_rst_i,
  input  logic                 i2s_enable,
  input  logic [DIV_WIDTH-1:0] i2s_sck_div,
  input  logic [31:0]          fifo_data_i,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  output logic                 i2s_sck_o,
  output logic                 i2s_ws_o,
  output logic                 i2s_sd_o,
  output logic                 underrun_error
);

  localparam logic [I2S_SLOT_W-1:0] SLOT_LAST_C = I2S_SLOT_W'(I2S_FRAME_BITS - 1);

  i2s_state_e                state_r, state_s;
  logic [DIV_WIDTH-1:0]      div_r;
  logic [I2S_SLOT_W-1:0]     slot_r, slot_nxt_s;
  logic [I2S_FRAME_BITS-1:0] shreg_r;
  logic                      sd_r, ws_r, underrun_r;
  logic                      run_s, sck_s, fall_evt_s, frame_end_s, load_s;

  i2s_to_wb_sck_gen #(.DIV_WIDTH(DIV_WIDTH)) u_sck_gen (
    .i2s_clk_i (i2s_clk_i),
    .i2s_rst_i (i2s_rst_i),
    .run       (run_s),
    .div       (div_r),
    .sck       (sck_s),
    .rise_evt  (),
    .fall_evt  (fall_evt_s)
  );

  // Frame-boundary decode; a returning enable during DRAIN keeps the stream going.
  always_comb begin
    run_s       = (state_r != ST_IDLE);
    slot_nxt_s  = slot_r + 5'd1;
    frame_end_s = fall_evt_s && (slot_r == SLOT_LAST_C);
    load_s      = frame_end_s && ((state_r == ST_RUN) || i2s_enable);
    fifo_pop    = load_s && !fifo_empty && !i2s_rst_i;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i2s_enable) state_s = ST_RUN;
        else            state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!i2s_enable) state_s = ST_DRAIN;
        else             state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (i2s_enable)       state_s = ST_RUN;
        else if (frame_end_s) state_s = ST_IDLE;
        else                  state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and divider latch taken on the IDLE->RUN transition.
  always_ff @(posedge i2s_clk_i) begin
    if (i2s_rst_i) begin
      state_r <= ST_IDLE;
      div_r   <= '0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && i2s_enable) div_r <= i2s_sck_div;
      else                                    div_r <= div_r;
    end
  end

  // Slot counter, shift register, WS/SD and sticky underrun; all move on fall events.
  always_ff @(posedge i2s_clk_i) begin
    if (i2s_rst_i || (state_r == ST_IDLE)) begin
      slot_r     <= SLOT_LAST_C;
      shreg_r    <= '0;
      sd_r       <= 1'b0;
      ws_r       <= 1'b0;
      underrun_r <= 1'b0;
    end else if (frame_end_s && !load_s) begin
      slot_r     <= SLOT_LAST_C;
      shreg_r    <= '0;
      sd_r       <= 1'b0;
      ws_r       <= 1'b0;
      underrun_r <= underrun_r;
    end else if (fall_evt_s) begin
      slot_r <= slot_nxt_s;
      ws_r   <= ws_for_slot(slot_nxt_s);
      if (load_s && !fifo_empty) begin
        shreg_r    <= fifo_data_i;
        sd_r       <= fifo_data_i[I2S_FRAME_BITS-1];
        underrun_r <= underrun_r;
      end else if (load_s) begin
        shreg_r    <= '0;
        sd_r       <= 1'b0;
        underrun_r <= 1'b1;
      end else begin
        shreg_r    <= {shreg_r[I2S_FRAME_BITS-2:0], 1'b0};
        sd_r       <= shreg_r[I2S_FRAME_BITS-2];
        underrun_r <= underrun_r;
      end
    end else begin
      slot_r     <= slot_r;
      shreg_r    <= shreg_r;
      sd_r       <= sd_r;
      ws_r       <= ws_r;
      underrun_r <= underrun_r;
    end
  end

  assign i2s_sck_o      = sck_s;
  assign i2s_ws_o       = ws_r;
  assign i2s_sd_o       = sd_r;
  assign underrun_error = underrun_r;

endmodule

// File: tb/tb_i2s_to_wb_tx_shifter.sv
// Directed + randomized bench: a FIFO model feeds the DUT, an I2S receiver model
// captures SD/WS on SCK rises, and a frame-level model predicts pops and bits.
module tb_i2s_to_wb_tx_shifter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          i2s_rst_i = 1'b1;
  logic          i2s_enable = 1'b0;
  logic [DW-1:0] i2s_sck_div = '0;
  logic [31:0]   fifo_data_i = 32'h0;
  logic          fifo_empty = 1'b1;
  logic          fifo_pop, i2s_sck_o, i2s_ws_o, i2s_sd_o, underrun_error;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] pool_q[$];
  logic        rx_sd[$];
  logic        rx_ws[$];
  logic        prev_sck = 1'b0;
  logic        pop_pend = 1'b0;
  int          refill_abs = -1;
  int          npre_g = 0;
  int          nref_g = 0;

  i2s_to_wb_tx_shifter #(.DIV_WIDTH(DW)) dut (
    .i2s_clk_i      (clk),
    .i2s_rst_i      (i2s_rst_i),
    .i2s_enable     (i2s_enable),
    .i2s_sck_div    (i2s_sck_div),
    .fifo_data_i    (fifo_data_i),
    .fifo_empty     (fifo_empty),
    .fifo_pop       (fifo_pop),
    .i2s_sck_o      (i2s_sck_o),
    .i2s_ws_o       (i2s_ws_o),
    .i2s_sd_o       (i2s_sd_o),
    .underrun_error (underrun_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void drive_fifo();
    fifo_empty  = (fifo_q.size() == 0);
    fifo_data_i = fifo_empty ? 32'h0 : fifo_q[0];
  endfunction

  // One clock: update FIFO model after the edge, sample the DUT on the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (cyc == refill_abs)
      for (int i = 0; i < nref_g; i++) fifo_q.push_back(pool_q[npre_g + i]);
    drive_fifo();
    @(negedge clk);
    pop_pend = fifo_pop;
    if (!prev_sck && i2s_sck_o) begin
      rx_sd.push_back(i2s_sd_o);
      rx_ws.push_back(i2s_ws_o);
    end
    prev_sck = i2s_sck_o;
  endtask

  task automatic session(input int div, input int n_pre, input int n_ref,
                         input int refill_rel, input int drop_rel, input int rst_rel);
    int t, c, n_fr, consumed, avail, kp, ku, p_end, last;
    int p[8];
    logic ld[8];
    logic [31:0] wd[8];
    logic un[8];
    logic any_un, exp_pop;
    logic [31:0] w, wsw;

    fifo_q.delete(); rx_sd.delete(); rx_ws.delete();
    prev_sck = 1'b0; pop_pend = 1'b0; refill_abs = -1;
    npre_g = n_pre; nref_g = n_ref;
    for (int i = 0; i < n_pre; i++) fifo_q.push_back(pool_q[i]);
    drive_fifo();
    i2s_rst_i = 1'b1; i2s_enable = 1'b1; i2s_sck_div = DW'(div);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("reset_outputs", {27'd0, fifo_pop, i2s_sck_o, i2s_ws_o, i2s_sd_o, underrun_error}, 32'd0);
    end
    i2s_rst_i = 1'b0;
    c = cyc;
    t = div + 1;
    refill_abs = (n_ref > 0) ? c + refill_rel : -1;

    // Frame model: boundary k at c+2T+64T*k; a word is taken if the FIFO holds one then.
    n_fr = 0;
    for (int k = 0; k < 8; k++) begin
      p[k] = c + 2*t + 64*t*k;
      if (p[k] <= c + drop_rel) n_fr = k + 1;
    end
    p_end = c + 2*t + 64*t*n_fr;
    consumed = 0; any_un = 1'b0;
    for (int k = 0; k < n_fr; k++) begin
      avail = n_pre + ((refill_abs >= 0 && refill_abs <= p[k]) ? n_ref : 0);
      if (consumed < avail) begin
        ld[k] = 1'b1; wd[k] = pool_q[consumed]; consumed++;
      end else begin
        ld[k] = 1'b0; wd[k] = 32'h0; any_un = 1'b1;
      end
      un[k] = any_un;
    end

    kp = 0; ku = 0;
    last = p_end + 4*t + 4;
    while (cyc < last) begin
      if (rst_rel >= 0 && cyc == c + rst_rel) begin
        i2s_rst_i = 1'b1;
        cycle();
        check("mid_frame_reset", {27'd0, fifo_pop, i2s_sck_o, i2s_ws_o, i2s_sd_o, underrun_error}, 32'd0);
        return;
      end
      if (cyc == c + drop_rel) i2s_enable = 1'b0;
      cycle();
      if (cyc == c + t)     check("sck_before_first_rise", {31'd0, i2s_sck_o}, 32'd0);
      if (cyc == c + t + 1) check("sck_first_rise", {31'd0, i2s_sck_o}, 32'd1);
      exp_pop = 1'b0;
      if (kp < n_fr && cyc == p[kp]) begin
        exp_pop = ld[kp];
        kp++;
      end
      check("fifo_pop", {31'd0, fifo_pop}, {31'd0, exp_pop});
      if (ku < n_fr && cyc == p[ku] + 1) begin
        check("underrun_flag", {31'd0, underrun_error}, {31'd0, un[ku]});
        ku++;
      end
      if (cyc > p_end)
        check("idle_outputs", {28'd0, i2s_sck_o, i2s_ws_o, i2s_sd_o, underrun_error},
              {28'd0, 3'b000, (cyc == p_end + 1) ? any_un : 1'b0});
    end

    // Receiver view: one pre-frame rise (idle SD/WS), then 32 rises per frame.
    check("rx_rise_count", rx_sd.size(), 1 + 32*n_fr);
    if (rx_sd.size() == 1 + 32*n_fr) begin
      check("pre_frame_slot", {30'd0, rx_ws[0], rx_sd[0]}, 32'd0);
      for (int k = 0; k < n_fr; k++) begin
        w = 32'h0; wsw = 32'h0;
        for (int n = 0; n < 32; n++) begin
          w   = {w[30:0], rx_sd[1 + 32*k + n]};
          wsw = {wsw[30:0], rx_ws[1 + 32*k + n]};
        end
        check("frame_sd_word", w, wd[k]);
        check("frame_ws_pattern", wsw, 32'h0001_FFFE);
      end
    end
  endtask

  task automatic fill_random(input int n);
    pool_q.delete();
    for (int i = 0; i < n; i++) pool_q.push_back($urandom());
  endtask

  initial begin
    int d, np, nr;

    // Single frame, div=1, enable drop in slot 10 of the only frame.
    pool_q.delete(); pool_q.push_back(32'hA5A5_3C3C);
    session(1, 1, 0, 0, 45, -1);

    // Underrun at frame 1, refill mid-frame 1, underrun again at frame 3.
    fill_random(2);
    session(2, 1, 1, 294, 632, -1);

    // Back-to-back frames at div=0.
    pool_q.delete(); pool_q.push_back(32'h8000_0001); pool_q.push_back(32'hFFFF_0000);
    session(0, 2, 0, 0, 86, -1);

    // FIFO refilled in the very cycle of the second frame boundary.
    fill_random(1);
    session(0, 0, 1, 66, 71, -1);

    // Reset inside slot 20 of the first frame.
    fill_random(2);
    session(1, 2, 0, 0, 100000, 85);

    // Randomized sessions.
    for (int r = 0; r < 4; r++) begin
      d  = $urandom_range(0, 3);
      np = $urandom_range(0, 2);
      nr = $urandom_range(0, 2);
      fill_random(np + nr);
      session(d, np, nr, $urandom_range(1, 130*(d+1)),
              2*(d+1) + $urandom_range(0, 192*(d+1) - 1), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
